// File: rtl/multicycle_datapath.sv
// Multicycle RV64I-subset core: FETCH/DECODE/EXEC/MEM/WB control FSM driving req/ack memory ports.
// Define MCDP_PERF_COUNTERS_EN to add the cycle_cnt/instret_cnt performance counter outputs.
module multicycle_datapath #(
    parameter int              XLEN      = 64,
    parameter int              NREG_LOG2 = 5,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    output logic                 imem_req,
    output logic [XLEN-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 retire,
    output logic                 halt,
    output logic [XLEN-1:0]      pc,
`ifdef MCDP_PERF_COUNTERS_EN
    output logic [63:0]          cycle_cnt,
    output logic [63:0]          instret_cnt,
`endif
    input  logic [NREG_LOG2-1:0] dbg_reg_addr,
    output logic [XLEN-1:0]      dbg_reg_data
);
    localparam int NREG = 1 << NREG_LOG2;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK = ~(XLEN'(1));

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, next_state;

    logic [31:0]            ir;
    logic [XLEN-1:0]        regs [NREG];
    logic [XLEN-1:0]        rs1_val, rs2_val, imm, result, npc;
    logic [XLEN-1:0]        exec_result, exec_npc;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   br_taken, legal, target_bad;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [NREG_LOG2-1:0] rd, rs1, rs2;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign rd     = ir[7 +: NREG_LOG2];
    assign rs1    = ir[15 +: NREG_LOG2];
    assign rs2    = ir[20 +: NREG_LOG2];
    assign rs1_s  = rs1_val;
    assign rs2_s  = rs2_val;

    assign imem_addr    = pc;
    assign dbg_reg_data = (dbg_reg_addr == '0) ? '0 : regs[dbg_reg_addr];

    // Immediates are assembled as signed 32-bit values, then sign-extended to XLEN.
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] insn);
        logic signed [31:0] v;
        case (insn[6:0])
            OP_STORE:  v = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OP_BRANCH: v = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
            OP_JAL:    v = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
            OP_LUI:    v = {insn[31:12], 12'b0};
            default:   v = {{20{insn[31]}}, insn[31:20]};
        endcase
        return XLEN'(v);
    endfunction

    always_comb begin
        case (opcode)
            OP_R, OP_IMM, OP_LUI, OP_LOAD, OP_STORE,
            OP_JAL, OP_JALR, OP_SYSTEM: legal = 1'b1;
            OP_BRANCH:                  legal = (funct3[2:1] != 2'b01);
            default:                    legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = (rs1_s < rs2_s);
            3'b101:  br_taken = (rs1_s >= rs2_s);
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Default result doubles as the load/store effective address.
    always_comb begin
        exec_result = rs1_val + imm;
        exec_npc    = pc + PC_STEP;
        case (opcode)
            OP_R:      exec_result = ir[30] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
            OP_LUI:    exec_result = imm;
            OP_BRANCH: if (br_taken) exec_npc = pc + imm;
            OP_JAL: begin
                exec_result = pc + PC_STEP;
                exec_npc    = pc + imm;
            end
            OP_JALR: begin
                exec_result = pc + PC_STEP;
                exec_npc    = (rs1_val + imm) & JALR_MASK;
            end
            default: ;
        endcase
    end

    assign target_bad = (exec_npc[1:0] != 2'b00);

    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (imem_req && imem_ack) next_state = DECODE;
            DECODE: next_state = legal ? EXEC : HALT;
            EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEM;
                    OP_SYSTEM:         next_state = HALT;
                    OP_BRANCH:         next_state = target_bad ? HALT : FETCH;
                    OP_JAL, OP_JALR:   next_state = target_bad ? HALT : WB;
                    default:           next_state = WB;
                endcase
            end
            MEM:     if (dmem_req && dmem_ack) next_state = dmem_we ? FETCH : WB;
            WB:      next_state = FETCH;
            default: next_state = HALT;
        endcase
    end

    // Control outputs, PC and architectural registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            retire   <= 1'b0;
            halt     <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            imem_req <= (next_state == FETCH);
            dmem_req <= (next_state == MEM);
            halt     <= halt | (next_state == HALT);
            retire   <= 1'b0;
            case (state)
                EXEC: begin
                    if (opcode == OP_LOAD || opcode == OP_STORE) dmem_we <= (opcode == OP_STORE);
                    if (opcode == OP_SYSTEM) retire <= 1'b1;
                    if (opcode == OP_BRANCH && !target_bad) begin
                        pc     <= exec_npc;
                        retire <= 1'b1;
                    end
                end
                MEM: begin
                    if (dmem_req && dmem_ack && dmem_we) begin
                        pc     <= npc;
                        retire <= 1'b1;
                    end
                end
                WB: begin
                    if (rd != '0) regs[rd] <= result;
                    pc     <= npc;
                    retire <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath holding registers; qualified by state, never reset.
    always_ff @(posedge CLK) begin
        case (state)
            FETCH: if (imem_req && imem_ack) ir <= imem_rdata;
            DECODE: begin
                rs1_val <= regs[rs1];
                rs2_val <= regs[rs2];
                imm     <= imm_gen(ir);
            end
            EXEC: begin
                result     <= exec_result;
                npc        <= exec_npc;
                dmem_addr  <= exec_result;
                dmem_wdata <= rs2_val;
            end
            MEM: if (dmem_req && dmem_ack && !dmem_we) result <= dmem_rdata;
            default: ;
        endcase
    end

`ifdef MCDP_PERF_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != HALT) cycle_cnt <= cycle_cnt + 64'd1;
            if (retire) instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: small program with hand-computed results and latencies.
module tb_multicycle_datapath;
    localparam int          XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            imem_req, imem_ack;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_req, dmem_we, dmem_ack;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            retire, halt;
    logic [XLEN-1:0] pc;
    logic [4:0]      dbg_reg_addr;
    logic [XLEN-1:0] dbg_reg_data;

    multicycle_datapath #(.XLEN(XLEN), .NREG_LOG2(5), .RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .halt(halt), .pc(pc),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data)
    );

    always #5 CLK = ~CLK;

    logic [31:0] imem [256];
    logic [63:0] dmem [128];
    int          dmem_wait = 0;
    int          dwait_cnt = 0;

    assign imem_ack   = imem_req;
    assign imem_rdata = imem[8'(imem_addr >> 2)];
    assign dmem_ack   = dmem_req && (dwait_cnt >= dmem_wait);
    assign dmem_rdata = dmem[7'(dmem_addr >> 3)];

    always @(posedge CLK) begin
        if (dmem_req && !dmem_ack) dwait_cnt <= dwait_cnt + 1;
        else                       dwait_cnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[7'(dmem_addr >> 3)] <= dmem_wdata;
    end

    // Data-port monitor: request cycles and whether addr/wdata/we stay put while pending.
    int          dreq_cycles = 0;
    int          dhold_bad   = 0;
    logic [63:0] last_daddr  = '0;
    logic [63:0] last_dwdata = '0;
    logic        last_dwe    = 1'b0;
    logic        pend        = 1'b0;
    always begin
        @(posedge CLK); #1;
        if (dmem_req) begin
            if (pend && (dmem_addr != last_daddr || dmem_wdata != last_dwdata || dmem_we != last_dwe))
                dhold_bad++;
            dreq_cycles++;
            last_daddr  = dmem_addr;
            last_dwdata = dmem_wdata;
            last_dwe    = dmem_we;
        end
        pend = dmem_req && !dmem_ack;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic run_to_retire(input string tag, input int exp_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!retire && n < 40);
        check_val(tag, 64'(n), 64'(exp_cyc));
    endtask

    task automatic watch(input int ncyc, output int n_ret, output int n_req);
        n_ret = 0;
        n_req = 0;
        repeat (ncyc) begin
            tick();
            if (retire) n_ret++;
            if (imem_req || dmem_req) n_req++;
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] r, input logic [63:0] exp);
        dbg_reg_addr = r;
        #1;
        check_val(tag, dbg_reg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nret, nreq;
        dbg_reg_addr = '0;

        imem[64] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_IMM);          // 0x100 addi x1,x0,5
        imem[65] = enc_r(7'h00, 5'd1, 5'd1, 5'd2);                  // 0x104 add  x2,x1,x1
        imem[66] = enc_r(7'h20, 5'd2, 5'd0, 5'd3);                  // 0x108 sub  x3,x0,x2
        imem[67] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, OP_IMM);          // 0x10C addi x0,x0,7
        imem[68] = enc_s(12'd8, 5'd2, 5'd0);                        // 0x110 sd   x2,8(x0)
        imem[69] = enc_i(12'd8, 5'd0, 3'b011, 5'd4, OP_LOAD);       // 0x114 ld   x4,8(x0)
        imem[70] = 32'h00108463;                                    // 0x118 beq  x1,x1,+8
        imem[71] = 32'h00100073;                                    // 0x11C ebreak (skipped)
        imem[72] = 32'h0011E463;                                    // 0x120 bltu x3,x1,+8
        imem[73] = 32'h00C002EF;                                    // 0x124 jal  x5,+12
        imem[74] = 32'h00100073;                                    // 0x128 ebreak (skipped)
        imem[75] = 32'h00100073;                                    // 0x12C ebreak (skipped)
        imem[76] = enc_i(12'h102, 5'd0, 3'd0, 5'd6, OP_IMM);        // 0x130 addi x6,x0,0x102
        imem[77] = enc_i(12'd0, 5'd6, 3'd0, 5'd7, OP_JALR);         // 0x134 jalr x7,0(x6)

        do_reset();
        check_val("rst_pc", pc, RST_PC);
        check_val("rst_halt", 64'(halt), 64'd0);
        check_val("rst_retire", 64'(retire), 64'd0);
        check_val("rst_imem_req", 64'(imem_req), 64'd0);
        check_val("rst_dmem_req", 64'(dmem_req), 64'd0);
        check_val("rst_dmem_we", 64'(dmem_we), 64'd0);
        tick();
        check_val("first_imem_req", 64'(imem_req), 64'd1);
        check_val("first_imem_addr", imem_addr, RST_PC);

        run_to_retire("lat_addi", 4);
        run_to_retire("lat_add", 4);
        run_to_retire("lat_sub", 4);
        check_reg("x1", 5'd1, 64'd5);
        check_reg("x2", 5'd2, 64'd10);
        check_reg("x3", 5'd3, 64'hFFFF_FFFF_FFFF_FFF6);
        run_to_retire("lat_addi_x0", 4);
        check_reg("x0", 5'd0, 64'd0);

        dmem_wait = 3;
        base = dreq_cycles;
        run_to_retire("lat_sd_wait3", 7);
        check_val("sd_req_cycles", 64'(dreq_cycles - base), 64'd4);
        check_val("sd_addr", last_daddr, 64'd8);
        check_val("sd_wdata", last_dwdata, 64'd10);
        check_val("sd_we", 64'(last_dwe), 64'd1);
        run_to_retire("lat_ld_wait3", 8);
        check_val("ld_addr", last_daddr, 64'd8);
        check_val("ld_we", 64'(last_dwe), 64'd0);
        check_val("dmem_hold", 64'(dhold_bad), 64'd0);
        check_reg("x4", 5'd4, 64'd10);
        dmem_wait = 0;

        run_to_retire("lat_beq", 3);
        check_val("beq_pc", pc, 64'h120);
        run_to_retire("lat_bltu", 3);
        check_val("bltu_pc", pc, 64'h124);
        run_to_retire("lat_jal", 4);
        check_val("jal_pc", pc, 64'h130);
        check_reg("x5", 5'd5, 64'h128);
        run_to_retire("lat_addi_x6", 4);
        check_reg("x6", 5'd6, 64'h102);

        watch(10, nret, nreq);
        check_val("jalr_halt", 64'(halt), 64'd1);
        check_val("jalr_retires", 64'(nret), 64'd0);
        check_val("jalr_reqs", 64'(nreq), 64'd0);
        check_val("jalr_pc", pc, 64'h134);
        check_reg("x7", 5'd7, 64'd0);

        imem[64] = 32'h0000007F;
        do_reset();
        check_val("ill_rst_halt", 64'(halt), 64'd0);
        tick();
        check_val("ill_imem_req", 64'(imem_req), 64'd1);
        watch(10, nret, nreq);
        check_val("ill_halt", 64'(halt), 64'd1);
        check_val("ill_retires", 64'(nret), 64'd0);
        check_val("ill_reqs", 64'(nreq), 64'd0);

        imem[64] = enc_i(12'd9, 5'd0, 3'd0, 5'd1, OP_IMM);          // 0x100 addi x1,x0,9
        imem[65] = enc_i(12'd16, 5'd0, 3'b011, 5'd8, OP_LOAD);      // 0x104 ld   x8,16(x0)
        dmem_wait = 30;
        do_reset();
        tick();
        run_to_retire("lat_addi_x1", 4);
        check_reg("x1_before_rst", 5'd1, 64'd9);
        repeat (5) tick();
        check_val("mem_wait_req", 64'(dmem_req), 64'd1);
        do_reset();
        check_val("mrst_dmem_req", 64'(dmem_req), 64'd0);
        check_val("mrst_pc", pc, RST_PC);
        check_reg("mrst_x8", 5'd8, 64'd0);
        check_reg("mrst_x1", 5'd1, 64'd0);
        imem[65] = 32'h00100073;                                    // 0x104 ebreak
        dmem_wait = 0;
        tick();
        check_val("mrst_imem_req", 64'(imem_req), 64'd1);
        check_val("mrst_imem_addr", imem_addr, RST_PC);
        run_to_retire("lat_addi_x1_again", 4);
        run_to_retire("lat_ebreak", 3);
        check_val("ebreak_halt", 64'(halt), 64'd1);
        watch(5, nret, nreq);
        check_val("ebreak_reqs", 64'(nreq), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
